// File: rtl/disp_pkg.sv
// Shared definitions for the display-path binary-to-BCD converter.
// Holds the FSM encoding, the BCD digit width and the constant helpers
// used to size the iteration counter and to check the digit count.
package disp_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_W = 4;

  // FSM encoding as plain constants, with a matching enum for readability.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2. Used with n = WIDTH+1 so the counter can hold WIDTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // 10**n as a 64-bit value, for the digit-count sanity check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_adj3_cell.sv
// Add-3 correction cell of the shift-and-add-3 (double dabble) algorithm.
// A digit of 5..9 becomes d+3 so that the following left shift carries
// into the next decade. Values 10..15 cannot arise in a correctly sized
// converter; they are forced to 0 so the cell has a defined output.
module bcd_adj3_cell
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  // Purely combinational digit correction.
  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_W'(10)) begin
      d_o = '0;
    end else if (d_i >= BCD_W'(5)) begin
      d_o = d_i + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// A start (accepted only while idle) loads {zero digits, bin} into a shift
// register; WIDTH SHIFT cycles each correct every digit (>=5 -> +3) and
// then shift the whole register left. The final digit field is registered
// into bcd with a one-cycle done pulse, so bcd only ever changes whole.
// Optional feature macro: BIN2BCD_BLANK_EN adds the leading-zero mask
// output blank, registered together with bcd.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]       blank
`endif
);

  localparam int DIG_W  = BCD_W * DIGITS;
  localparam int SREG_W = DIG_W + WIDTH;
  localparam int CNT_W  = clog2(WIDTH + 1);

  localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

  // The digit field must be able to hold the largest input value.
  generate
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_small
      $error("bin2bcd_seq: DIGITS=%0d cannot represent %0d-bit input", DIGITS, WIDTH);
    end
  endgenerate

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  logic [0:0]        state_q, state_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [SREG_W-1:0] sreg_q,  sreg_d;
  logic [DIG_W-1:0]  bcd_q,   bcd_d;

  // --------------------------------------------------------------------
  // Datapath: correct every digit, then shift the whole register by one
  // --------------------------------------------------------------------
  logic [DIG_W-1:0]  digits_cur;
  logic [DIG_W-1:0]  digits_adj;
  logic [SREG_W-1:0] sreg_shift;
  logic [DIG_W-1:0]  digits_shifted;
  logic              last_shift;
  logic              adj_msb_unused;

  assign digits_cur = sreg_q[SREG_W-1 -: DIG_W];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_adj3_cell u_cell (
        .d_i (digits_cur[gi*BCD_W +: BCD_W]),
        .d_o (digits_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // The top bit of the corrected field is shifted out; with a correctly
  // sized DIGITS it is always zero.
  assign adj_msb_unused = digits_adj[DIG_W-1];

  assign sreg_shift     = {digits_adj[DIG_W-2:0], sreg_q[WIDTH-1:0], 1'b0};
  assign digits_shifted = sreg_shift[SREG_W-1 -: DIG_W];
  assign last_shift     = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BIN2BCD_BLANK_EN
  // --------------------------------------------------------------------
  // Leading-zero mask: digit i (i>=1) blanks when it and every higher
  // digit are zero. Digit 0 is never blanked so zero still shows "0".
  // --------------------------------------------------------------------
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_calc;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_ones
        assign blank_calc[gi] = 1'b0;
      end else if (gi == DIGITS - 1) begin : g_top
        assign blank_calc[gi] = (digits_shifted[gi*BCD_W +: BCD_W] == '0);
      end else begin : g_mid
        assign blank_calc[gi] = (digits_shifted[gi*BCD_W +: BCD_W] == '0)
                                && blank_calc[gi+1];
      end
    end
  endgenerate
`endif

  // --------------------------------------------------------------------
  // Next-state logic for the IDLE/SHIFT sequencer
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    bcd_d   = bcd_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          cnt_d   = '0;
          sreg_d  = {{DIG_W{1'b0}}, bin};
        end
      end
      SHIFT: begin
        sreg_d = sreg_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_shift) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = digits_shifted;
`ifdef BIN2BCD_BLANK_EN
          blank_d = blank_calc;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      bcd_q   <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      bcd_q   <= bcd_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN2BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq (WIDTH=8, DIGITS=3).
// Define BIN2BCD_BLANK_EN for both DUT and bench to exercise blank.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank;
`endif

  int n_vec;
  int n_err;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference model for 8-bit input.
  function automatic logic [11:0] dec_model(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One complete conversion: start pulse, WIDTH busy cycles, then done.
  task automatic do_conv(input logic [7:0] v, input logic [11:0] exp_bcd,
                         input logic [2:0] exp_blank);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);                    // accept edge has passed
    start = 1'b0;
    bin   = ~v;                        // must not affect the conversion
    chk("busy_c1", 32'(busy), 32'd1);
    chk("done_c1", 32'(done), 32'd0);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) chk("busy_hold", 32'(busy), 32'd1);
      if (done !== 1'b0) chk("done_early", 32'(done), 32'd0);
    end
    @(negedge clk);                    // cycle after edge k+8
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk($sformatf("bcd_%0d", v), 32'(bcd), 32'(exp_bcd));
`ifdef BIN2BCD_BLANK_EN
    chk($sformatf("blank_%0d", v), 32'(blank), 32'(exp_blank));
`else
    if (exp_blank === 3'bxxx) chk("blank_arg", 32'(exp_blank), 32'd0);
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk($sformatf("bcd_hold_%0d", v), 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    int ndone;
    logic [11:0] cap;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    start = 1'b1;                      // start during reset must be ignored
    bin   = 8'd77;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    chk("rst_blank", 32'(blank), 32'd0);
`endif
    start = 1'b0;
    rst   = 1'b0;

    // Full-scale, zero, and assorted values
    do_conv(8'd255, 12'h255, 3'b000);
    do_conv(8'd0,   12'h000, 3'b110);
    do_conv(8'd99,  12'h099, 3'b100);
    do_conv(8'd100, 12'h100, 3'b000);
    do_conv(8'd7,   12'h007, 3'b110);

    // Start while busy is ignored, no queueing
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd42;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap   = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        cap = bcd;
      end
    end
    chk("ignored_ndone", 32'(ndone), 32'd1);
    chk("ignored_bcd", 32'(cap), 32'h042);
    chk("ignored_idle", 32'(busy), 32'd0);

    // Reset in the middle of a conversion aborts it
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd180;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    do_conv(8'd180, 12'h180, 3'b000);

    // Start held high: back-to-back conversions of 0..255
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd0;
    for (int v = 0; v < 256; v++) begin
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (c < 9) begin
          bin = 8'($urandom);          // ignored while busy
        end
      end
      chk($sformatf("b2b_done_%0d", v), 32'(done), 32'd1);
      chk($sformatf("b2b_bcd_%0d", v), 32'(bcd), 32'(dec_model(v)));
`ifdef BIN2BCD_BLANK_EN
      chk($sformatf("b2b_blank_%0d", v), 32'(blank),
          32'({(v < 100), (v < 10), 1'b0}));
`endif
      bin = 8'(v + 1);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
